// File: rtl/fire_alarm_pkg.sv
// Shared types and default constants for the fire alarm controller and its zone debouncers.
// State encoding is visible on the controller's state output.
package fire_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALARM    = 2'd1,
        ST_SILENCED = 2'd2,
        ST_CALLED   = 2'd3
    } fa_state_e;

    localparam int DEFAULT_ZONES      = 4;
    localparam int DEFAULT_DEBOUNCE   = 3;
    localparam int DEFAULT_CALL_DELAY = 16;
    localparam int DEB_W              = 4;

    // Delay counter must be able to hold CALL_DELAY itself
    function automatic int delay_width(input int call_delay);
        return $clog2(call_delay + 1);
    endfunction

endpackage

// File: rtl/fire_zone_debounce.sv
// One detector zone: counts consecutive active cycles and reports a single-cycle
// confirmation pulse, flagged as heat when heat was present for the whole counted run.
module fire_zone_debounce
    import fire_alarm_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic smoke_i,
    input  logic heat_i,
    input  logic clr_i,
    output logic confirm_o,
    output logic heat_confirm_o
);

    localparam logic [DEB_W-1:0] CNT_MAX  = DEB_W'(DEBOUNCE);
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEBOUNCE - 1);

    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             heat_all_q, heat_all_d;
    logic             active;
    logic             heat_run;

    always_comb begin
        active     = smoke_i | heat_i;
        // A fresh run starts its heat history from the current sample only
        heat_run   = (cnt_q == '0) ? heat_i : (heat_all_q & heat_i);
        cnt_d      = '0;
        heat_all_d = 1'b0;
        if (!clr_i && active) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d      = cnt_q;
                heat_all_d = heat_all_q;
            end else begin
                cnt_d      = cnt_q + DEB_W'(1);
                heat_all_d = heat_run;
            end
        end
        confirm_o      = active && (cnt_q == CNT_LAST);
        heat_confirm_o = confirm_o && heat_run;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            heat_all_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            heat_all_q <= heat_all_d;
        end
    end

endmodule

// File: rtl/fire_alarm_controller.sv
// Fire alarm controller: per-zone debounced alarm latches, an escalation FSM with
// operator ack/clear, and a delayed external call for smoke-only events.
module fire_alarm_controller
    import fire_alarm_pkg::*;
#(
    parameter int ZONES      = DEFAULT_ZONES,
    parameter int DEBOUNCE   = DEFAULT_DEBOUNCE,
    parameter int CALL_DELAY = DEFAULT_CALL_DELAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ZONES-1:0] smoke_detector,
    input  logic [ZONES-1:0] heat_detector,
    input  logic             ack,
    input  logic             clear,
    output logic [ZONES-1:0] fire_alarm,
    output logic             call,
    output logic [1:0]       state
);

    localparam int               DLY_W    = delay_width(CALL_DELAY);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(CALL_DELAY - 1);

    logic [ZONES-1:0] confirm;
    logic [ZONES-1:0] heat_confirm;
    logic             quiet;
    logic             clr_ok;
    logic             any_conf;
    logic             any_heat;
    logic             new_conf;

    fa_state_e        state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [ZONES-1:0] fire_alarm_q, fire_alarm_d;
    logic             call_q, call_d;

    generate
        for (genvar gi = 0; gi < ZONES; gi++) begin : g_zone
            fire_zone_debounce #(
                .DEBOUNCE(DEBOUNCE)
            ) u_zone (
                .clk           (clk),
                .reset         (reset),
                .smoke_i       (smoke_detector[gi]),
                .heat_i        (heat_detector[gi]),
                .clr_i         (clr_ok),
                .confirm_o     (confirm[gi]),
                .heat_confirm_o(heat_confirm[gi])
            );
        end
    endgenerate

    always_comb begin
        quiet        = ~|{smoke_detector, heat_detector};
        clr_ok       = clear & quiet;
        any_conf     = |confirm;
        any_heat     = |heat_confirm;
        new_conf     = |(confirm & ~fire_alarm_q);
        state_d      = state_q;
        dly_d        = dly_q;
        fire_alarm_d = fire_alarm_q | confirm;

        if (clr_ok) begin
            state_d      = ST_IDLE;
            dly_d        = '0;
            fire_alarm_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_heat) begin
                        state_d = ST_CALLED;
                    end else if (any_conf) begin
                        state_d = ST_ALARM;
                        dly_d   = '0;
                    end
                end
                ST_ALARM: begin
                    // Heat beats delay expiry, which beats an operator ack
                    dly_d = dly_q + DLY_W'(1);
                    if (any_heat || (dly_q == DLY_LAST)) begin
                        state_d = ST_CALLED;
                    end else if (ack) begin
                        state_d = ST_SILENCED;
                    end
                end
                ST_SILENCED: begin
                    if (any_heat) begin
                        state_d = ST_CALLED;
                    end else if (new_conf) begin
                        state_d = ST_ALARM;
                    end
                end
                ST_CALLED: state_d = ST_CALLED;
                default:   state_d = ST_IDLE;
            endcase
        end

        call_d = (state_d == ST_CALLED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dly_q        <= '0;
            fire_alarm_q <= '0;
            call_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            fire_alarm_q <= fire_alarm_d;
            call_q       <= call_d;
        end
    end

    assign fire_alarm = fire_alarm_q;
    assign call       = call_q;
    assign state      = state_q;

endmodule

// File: tb/tb_fire_alarm_controller.sv
// Scoreboard bench for fire_alarm_controller: directed scenarios plus random detector
// bursts, all checked against a run-length based reference model.
module tb_fire_alarm_controller;

    localparam int Z  = 4;
    localparam int DB = 3;
    localparam int CD = 16;

    localparam int M_IDLE     = 0;
    localparam int M_ALARM    = 1;
    localparam int M_SILENCED = 2;
    localparam int M_CALLED   = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [Z-1:0] smoke = '0;
    logic [Z-1:0] heat = '0;
    logic         ack = 1'b0;
    logic         clear = 1'b0;
    logic [Z-1:0] fire_alarm;
    logic         call;
    logic [1:0]   state;

    fire_alarm_controller #(
        .ZONES(Z),
        .DEBOUNCE(DB),
        .CALL_DELAY(CD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .smoke_detector(smoke),
        .heat_detector (heat),
        .ack           (ack),
        .clear         (clear),
        .fire_alarm    (fire_alarm),
        .call          (call),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [Z-1:0] fa;
        logic         call;
        logic [1:0]   st;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: consecutive-cycle run lengths per zone and cycles spent alarming
    int           m_run[Z];
    int           m_hrun[Z];
    logic [Z-1:0] m_fa;
    int           m_st;
    int           m_elapsed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < Z; z++) begin
            m_run[z]  = 0;
            m_hrun[z] = 0;
        end
        m_fa      = '0;
        m_st      = M_IDLE;
        m_elapsed = 0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.fa   = m_fa;
        e.call = (m_st == M_CALLED);
        e.st   = 2'(m_st);
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic [Z-1:0] sm, input logic [Z-1:0] ht,
                              input logic a, input logic c);
        logic [Z-1:0] conf;
        logic [Z-1:0] hconf;
        logic [Z-1:0] fresh;
        conf  = '0;
        hconf = '0;
        if (c && sm == '0 && ht == '0) begin
            model_reset();
        end else begin
            for (int z = 0; z < Z; z++) begin
                m_run[z]  = (sm[z] || ht[z]) ? m_run[z] + 1 : 0;
                m_hrun[z] = ht[z] ? m_hrun[z] + 1 : 0;
                if (m_run[z] == DB) conf[z] = 1'b1;
                if (m_run[z] == DB && m_hrun[z] >= DB) hconf[z] = 1'b1;
            end
            fresh = conf & ~m_fa;
            m_fa  = m_fa | conf;
            case (m_st)
                M_IDLE: begin
                    if (hconf != '0) m_st = M_CALLED;
                    else if (conf != '0) begin
                        m_st      = M_ALARM;
                        m_elapsed = 0;
                    end
                end
                M_ALARM: begin
                    m_elapsed++;
                    if (hconf != '0 || m_elapsed == CD) m_st = M_CALLED;
                    else if (a) m_st = M_SILENCED;
                end
                M_SILENCED: begin
                    if (hconf != '0) m_st = M_CALLED;
                    else if (fresh != '0) m_st = M_ALARM;
                end
                default: ;
            endcase
        end
        push_expect();
    endtask

    // Called at posedge+2; drives one cycle of inputs and moves past the next edge
    task automatic cyc(input logic [Z-1:0] sm, input logic [Z-1:0] ht,
                       input logic a, input logic c);
        smoke = sm;
        heat  = ht;
        ack   = a;
        clear = c;
        model_step(sm, ht, a, c);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, '0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        exp_t e;
        reset = 1'b1;
        #1;
        check("async_rst_fa", 32'(fire_alarm), 32'd0);
        check("async_rst_call", 32'(call), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        model_reset();
        e = '0;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_fire_alarm", 32'(fire_alarm), 32'(e.fa));
                check("mon_call", 32'(call), 32'(e.call));
                check("mon_state", 32'(state), 32'(e.st));
            end
        end
    end

    initial begin
        int           blen[Z];
        int           btype[Z];
        logic [Z-1:0] sm;
        logic [Z-1:0] ht;
        logic         a;
        logic         c;

        @(posedge clk);
        #2;
        check("reset_fa", 32'(fire_alarm), 32'd0);
        check("reset_call", 32'(call), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        reset = 1'b0;
        model_reset();

        // Smoke on zone 1 for three cycles, then the delayed call
        repeat (3) cyc(4'b0010, '0, 1'b0, 1'b0);
        check("smoke_fa", 32'(fire_alarm), 32'h2);
        check("smoke_state", 32'(state), 32'd1);
        idle(15);
        check("call_not_early", 32'(call), 32'd0);
        idle(1);
        check("call_on_time", 32'(call), 32'd1);
        check("called_state", 32'(state), 32'd3);
        cyc('0, '0, 1'b0, 1'b1);
        check("clear_state", 32'(state), 32'd0);

        // Interrupted smoke never confirms
        repeat (2) cyc(4'b0100, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        repeat (2) cyc(4'b0100, '0, 1'b0, 1'b0);
        check("glitch_fa", 32'(fire_alarm), 32'd0);
        check("glitch_state", 32'(state), 32'd0);
        idle(1);

        // Heat goes straight to CALLED; clear ignored while heat persists
        repeat (3) cyc('0, 4'b1000, 1'b0, 1'b0);
        check("heat_fa", 32'(fire_alarm), 32'h8);
        check("heat_state", 32'(state), 32'd3);
        check("heat_call", 32'(call), 32'd1);
        cyc('0, 4'b1000, 1'b0, 1'b1);
        check("busy_clear_fa", 32'(fire_alarm), 32'h8);
        check("busy_clear_state", 32'(state), 32'd3);
        cyc('0, '0, 1'b0, 1'b1);
        check("quiet_clear_fa", 32'(fire_alarm), 32'd0);
        check("quiet_clear_call", 32'(call), 32'd0);
        check("quiet_clear_state", 32'(state), 32'd0);

        // Ack silences and holds the delay; a new zone resumes it
        repeat (3) cyc(4'b0001, '0, 1'b0, 1'b0);
        idle(4);
        cyc('0, '0, 1'b1, 1'b0);
        idle(40);
        check("silenced_call", 32'(call), 32'd0);
        check("silenced_state", 32'(state), 32'd2);
        repeat (3) cyc(4'b0100, '0, 1'b0, 1'b0);
        check("resume_state", 32'(state), 32'd1);
        check("resume_fa", 32'(fire_alarm), 32'h5);
        idle(10);
        check("resume_call_early", 32'(call), 32'd0);
        idle(1);
        check("resume_call", 32'(call), 32'd1);
        cyc('0, '0, 1'b0, 1'b1);

        // Reset mid-ALARM with smoke held, then full re-confirmation
        repeat (7) cyc(4'b0010, '0, 1'b0, 1'b0);
        pulse_reset();
        repeat (2) cyc(4'b0010, '0, 1'b0, 1'b0);
        check("reconf_early_fa", 32'(fire_alarm), 32'd0);
        cyc(4'b0010, '0, 1'b0, 1'b0);
        check("reconf_fa", 32'(fire_alarm), 32'h2);
        check("reconf_state", 32'(state), 32'd1);
        cyc('0, '0, 1'b0, 1'b1);

        // Random detector bursts with sporadic ack, clear and reset
        for (int z = 0; z < Z; z++) begin
            blen[z]  = 0;
            btype[z] = 0;
        end
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset();
            sm = '0;
            ht = '0;
            for (int z = 0; z < Z; z++) begin
                if (blen[z] == 0 && $urandom_range(0, 15) == 0) begin
                    blen[z]  = int'($urandom_range(1, 6));
                    btype[z] = int'($urandom_range(0, 2));
                end
                if (blen[z] > 0) begin
                    blen[z]--;
                    case (btype[z])
                        0:       sm[z] = 1'b1;
                        1:       ht[z] = 1'b1;
                        default: begin
                            sm[z] = 1'b1;
                            ht[z] = ($urandom_range(0, 3) != 0);
                        end
                    endcase
                end
            end
            a = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 39) == 0);
            cyc(sm, ht, a, c);
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fire_alarm_controller.md
FIRE_ALARM_CONTROLLER -- requirements
Module: fire_alarm_controller

Interface
REQ-001 Parameter ZONES, default 4, number of detector zones (1..16).
REQ-002 Parameter DEBOUNCE, default 3, consecutive active cycles before a zone is confirmed (1..15).
REQ-003 Parameter CALL_DELAY, default 16, cycles from first smoke-only confirmation to external call (1..255).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 smoke_detector  input  ZONES  per-zone smoke sensor, active-high.
REQ-007 heat_detector  input  ZONES  per-zone heat sensor, active-high.
REQ-008 ack  input  1  operator acknowledge, single-cycle pulse.
REQ-009 clear  input  1  operator clear/re-arm, single-cycle pulse.
REQ-010 fire_alarm  output  ZONES  latched per-zone alarm indication.
REQ-011 call  output  1  external fire-service call, latched.
REQ-012 state  output  2  current controller state encoding.

Function
REQ-013 Each zone SHALL have a debounce counter that increments while (smoke|heat) is high, saturates at DEBOUNCE, and resets to 0 on any low cycle.
REQ-014 A zone SHALL be confirmed in the cycle its counter reaches DEBOUNCE; its fire_alarm bit SHALL rise on the next clock edge and stay set until a successful clear.
REQ-015 A zone SHALL be heat-confirmed if heat_detector was high in every one of its DEBOUNCE counted cycles; otherwise it is smoke-confirmed.
REQ-016 FSM states: IDLE=0, ALARM=1, SILENCED=2, CALLED=3.
REQ-017 IDLE -> ALARM on any smoke-confirmed zone; IDLE or ALARM or SILENCED -> CALLED on any heat-confirmed zone (heat has priority in the same cycle).
REQ-018 On entry to ALARM the delay counter SHALL load 0 and increment once per cycle in ALARM.
REQ-019 ALARM -> CALLED when the delay counter reaches CALL_DELAY-1, i.e. call rises exactly CALL_DELAY cycles after the fire_alarm bit.
REQ-020 ALARM -> SILENCED on ack; the delay counter SHALL hold while SILENCED.
REQ-021 SILENCED -> ALARM (counter resumes, not reloaded) on confirmation of any zone not previously latched.
REQ-022 ack in IDLE or CALLED SHALL have no effect.
REQ-023 call SHALL be 1 exactly while in CALLED; CALLED is left only by a successful clear or reset.
REQ-024 clear SHALL succeed only when all smoke_detector and heat_detector bits are 0 in that cycle; it SHALL then zero fire_alarm, all debounce counters and the delay counter, and return the FSM to IDLE on the next edge.
REQ-025 clear while any detector is active SHALL be ignored entirely.
REQ-026 ack and clear in the same cycle: clear takes precedence when successful; otherwise ack applies.
REQ-027 A zone confirming in the same cycle as a successful clear SHALL be impossible by REQ-024; debounce counts already accumulated are discarded.
REQ-028 Delay counter width SHALL be ceil(log2(CALL_DELAY+1)); debounce counter width 4 bits.

Reset
REQ-029 reset SHALL asynchronously force fire_alarm=0, call=0, state=IDLE, all counters=0.
REQ-030 Reset asserted mid-ALARM or mid-CALLED SHALL abort immediately; after release, re-confirmation needs a full DEBOUNCE count.
REQ-031 All outputs SHALL be registered; no combinational input-to-output path.

Structure
REQ-032 A shared package fire_alarm_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-033 Per-zone debounce and heat-qualification SHALL be a sub-module fire_zone_debounce, instantiated ZONES times by generate.

Verification
REQ-034 Defaults, smoke[1]=1 held for 3 cycles -> fire_alarm=4'b0010 after 3rd edge, state=ALARM, call=1 exactly 16 cycles later.
REQ-035 smoke[2] high 2 cycles, low 1, high 2 -> fire_alarm stays 0, state stays IDLE.
REQ-036 heat[3]=1 for 3 cycles -> fire_alarm=4'b1000 and state=CALLED, call=1 on the same edge.
REQ-037 smoke[0] confirmed, ack after 5 cycles, wait 40 cycles -> call=0, state=SILENCED; then smoke[2] confirmed -> ALARM, call=1 after 11 further cycles.
REQ-038 In CALLED, clear with heat[3] still high -> no change; drop heat, clear -> next edge fire_alarm=0, call=0, state=IDLE.
REQ-039 reset pulsed 4 cycles into ALARM -> outputs zero immediately (asynchronous); detectors held high -> re-confirm after 3 cycles.
